aer_spike_serializer: RTL and testbench
=======================================

AER_SPIKE_SERIALIZER -- requirements
Module: aer_spike_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: spike bits per input word.
REQ-002 SHALL have parameter NUM_INPUTS, default 784: neurons per timestep.
REQ-003 SHALL have parameter NUM_STEPS, default 16: timesteps per frame.
REQ-004 SHALL have parameter ADDR_W, default 12: AER address width; elaboration error if ADDR_W < 2+clog2(NUM_INPUTS).
REQ-005 SHALL have parameter MSB_FIRST, default 1: 1 = bit DATA_WIDTH-1 is the lowest neuron index; 0 = bit 0 is.
REQ-006 SHALL have port CLK  in  1  clock.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  in  1  single-cycle frame-start pulse.
REQ-009 SHALL have port din  in  DATA_WIDTH  packed spike word.
REQ-010 SHALL have port din_valid  in  1  din qualifier.
REQ-011 SHALL have port din_ready  out  1  word accepted when din_valid && din_ready.
REQ-012 SHALL have port aer_req  out  1  4-phase request.
REQ-013 SHALL have port aer_ack  in  1  4-phase acknowledge.
REQ-014 SHALL have port aer_addr  out  ADDR_W  event address, stable while aer_req=1.
REQ-015 SHALL have ports busy, step_done, frame_done  out  1 each  status; done outputs are 1-cycle pulses.

Function
REQ-016 SHALL use states IDLE, LOAD, SCAN, REQ, ACKLOW, MARK, DONE.
REQ-017 IDLE: start=1 clears neuron counter and step counter, goes to LOAD; start ignored in every other state.
REQ-018 LOAD: din_ready=1 (registered, only in LOAD); on accept, latch din, go to SCAN.
REQ-019 SCAN: examine one bit per cycle; zero bit -> increment neuron index, no event; set bit -> drive aer_addr={2'b00, index zero-extended}, go to REQ.
REQ-020 aer_req SHALL rise on the clock edge after SCAN sees a set bit; the first examined bit is evaluated in the cycle after accept.
REQ-021 REQ: hold aer_req=1 until aer_ack=1, then drop aer_req on the next edge, go to ACKLOW.
REQ-022 ACKLOW: wait for aer_ack=0, then increment neuron index and return to SCAN; no new request while aer_ack=1.
REQ-023 Word exhausted (DATA_WIDTH bits done) with index < NUM_INPUTS -> LOAD.
REQ-024 Index reaching NUM_INPUTS -> MARK; remaining bits of a partial last word SHALL be discarded without events.
REQ-025 MARK: one 4-phase event with aer_addr={2'b01, step index zero-extended}; after ack low, pulse step_done, clear neuron index, increment step index.
REQ-026 After marker of step NUM_STEPS-1 -> DONE: pulse frame_done one cycle, return to IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 aer_ack=1 while in SCAN or LOAD SHALL be ignored (no state change, no req).
REQ-029 Neuron index width clog2(NUM_INPUTS+1); step index width clog2(NUM_STEPS+1); no wrap within a frame.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, aer_req=0, aer_addr=0, din_ready=0, busy=0, step_done=0, frame_done=0, counters=0, shift register=0, including mid-handshake.

Structure
REQ-031 Package aer_pkg SHALL hold state enum, prefix constants AER_PFX_SPIKE=2'b00 and AER_PFX_MARK=2'b01.
REQ-032 4-phase REQ/ACK sequencing SHALL be a sub-module aer_handshake_tx (start/addr in, req/ack, done pulse out), used for both spike and marker events.

Verification
REQ-033 NUM_INPUTS=8, NUM_STEPS=1, MSB_FIRST=1, words 4'b1000,4'b0001, ack responds 2 cycles -> addrs 0x000,0x007,0x400; one step_done, one frame_done.
REQ-034 Same words, MSB_FIRST=0 -> addrs 0x003,0x004,0x400.
REQ-035 NUM_INPUTS=6, words 4'b1111,4'b1111 -> addrs 0x000..0x005 only, then marker 0x400; bits 6,7 dropped.
REQ-036 NUM_STEPS=3, all-zero words -> only markers 0x400,0x401,0x402, three step_done, frame_done after third.
REQ-037 rst_n pulsed low while aer_req=1 and aer_ack=1 -> aer_req=0 same cycle, IDLE, next start restarts at index 0.
REQ-038 Ack held high 10 cycles after req drop -> no second aer_req until ack low; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared types and address-prefix constants for the AER spike serializer.
package aer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SCAN,
      REQ,
      ACKLOW,
      MARK,
      DONE
   } aer_state_e;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_REQ,
      HS_WAIT
   } hs_state_e;

   localparam logic [1:0] AER_PFX_SPIKE = 2'b00;
   localparam logic [1:0] AER_PFX_MARK  = 2'b01;

endpackage

// File: rtl/aer_handshake_tx.sv
// Four-phase REQ/ACK transmitter: launches one event per start pulse and
// pulses done once the receiver has released ack after the request drops.
module aer_handshake_tx
   import aer_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              aer_ack,
   output logic              aer_req,
   output logic [ADDR_W-1:0] aer_addr,
   output logic              done
);

   hs_state_e         state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              done_q, done_d;

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      case (state_q)
         HS_IDLE: begin
            if (start) begin
               req_d   = 1'b1;
               addr_d  = addr_in;
               state_d = HS_REQ;
            end
         end
         HS_REQ: begin
            if (aer_ack) begin
               req_d   = 1'b0;
               state_d = HS_WAIT;
            end
         end
         HS_WAIT: begin
            // A new event may only follow once the receiver has let go of ack.
            if (!aer_ack) begin
               done_d  = 1'b1;
               state_d = HS_IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = HS_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HS_IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

   assign aer_req  = req_q;
   assign aer_addr = addr_q;
   assign done     = done_q;

endmodule

// File: rtl/aer_spike_serializer.sv
// Serializes packed spike words of a frame into AER events, one step marker
// per timestep and a frame_done pulse after the last step.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | din_ready high, waiting to accept the next spike word
// SCAN   | examining one bit of the latched word per cycle
// REQ    | spike event request out, waiting for ack
// ACKLOW | spike request dropped, waiting for ack release
// MARK   | step marker event in flight
// DONE   | one-cycle frame_done
module aer_spike_serializer
   import aer_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_INPUTS = 784,
   parameter int NUM_STEPS  = 16,
   parameter int ADDR_W     = 12,
   parameter int MSB_FIRST  = 1
) (
   input  logic                  CLK,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic                  aer_req,
   input  logic                  aer_ack,
   output logic [ADDR_W-1:0]     aer_addr,
   output logic                  busy,
   output logic                  step_done,
   output logic                  frame_done
);

   localparam int IDX_W  = $clog2(NUM_INPUTS + 1);
   localparam int STEP_W = $clog2(NUM_STEPS + 1);
   localparam int BCNT_W = $clog2(DATA_WIDTH + 1);
   localparam int PAY_W  = ADDR_W - 2;

   localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(NUM_INPUTS);
   localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
   localparam logic [STEP_W-1:0] STEP_END  = STEP_W'(NUM_STEPS);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
   localparam logic [BCNT_W-1:0] BCNT_END  = BCNT_W'(DATA_WIDTH);
   localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);

   if (ADDR_W < 2 + $clog2(NUM_INPUTS)) begin : g_addr_w_check
      $error("aer_spike_serializer: ADDR_W too narrow for NUM_INPUTS");
   end

   aer_state_e            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic                  din_ready_q, din_ready_d;
   logic                  busy_q, busy_d;
   logic                  step_done_q, step_done_d;
   logic                  frame_done_q, frame_done_d;

   logic [IDX_W-1:0]      idx_inc;
   logic [STEP_W-1:0]     step_inc;
   logic [BCNT_W-1:0]     bcnt_inc;
   logic                  cur_bit;
   logic [DATA_WIDTH-1:0] sh_next;
   logic [ADDR_W-1:0]     spike_addr;
   logic [ADDR_W-1:0]     mark_addr;
   logic                  advance;
   logic                  hs_start;
   logic [ADDR_W-1:0]     hs_addr;
   logic                  hs_done;

   assign idx_inc    = idx_q + IDX_ONE;
   assign step_inc   = step_q + STEP_ONE;
   assign bcnt_inc   = bcnt_q + BCNT_ONE;
   assign cur_bit    = (MSB_FIRST != 0) ? sh_q[DATA_WIDTH-1] : sh_q[0];
   assign sh_next    = (MSB_FIRST != 0) ? (sh_q << 1) : (sh_q >> 1);
   assign spike_addr = {AER_PFX_SPIKE, PAY_W'(idx_q)};
   assign mark_addr  = {AER_PFX_MARK, PAY_W'(step_q)};

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      step_d      = step_q;
      bcnt_d      = bcnt_q;
      sh_d        = sh_q;
      step_done_d = 1'b0;
      advance     = 1'b0;
      hs_start    = 1'b0;
      hs_addr     = spike_addr;

      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d   = '0;
               step_d  = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (din_valid && din_ready_q) begin
               sh_d    = din;
               bcnt_d  = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            sh_d   = sh_next;
            bcnt_d = bcnt_inc;
            if (cur_bit) begin
               hs_start = 1'b1;
               state_d  = REQ;
            end else begin
               idx_d   = idx_inc;
               advance = 1'b1;
            end
         end
         REQ: begin
            if (aer_ack) begin
               state_d = ACKLOW;
            end
         end
         ACKLOW: begin
            if (hs_done) begin
               idx_d   = idx_inc;
               advance = 1'b1;
            end
         end
         MARK: begin
            if (hs_done) begin
               step_done_d = 1'b1;
               idx_d       = '0;
               step_d      = step_inc;
               state_d     = (step_inc == STEP_END) ? DONE : LOAD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Last neuron of the step wins over the word boundary, so leftover bits
      // of a partial final word are dropped when LOAD refills the shifter.
      if (advance) begin
         if (idx_inc == IDX_END) begin
            state_d  = MARK;
            hs_start = 1'b1;
            hs_addr  = mark_addr;
         end else if (bcnt_d == BCNT_END) begin
            state_d = LOAD;
         end else begin
            state_d = SCAN;
         end
      end

      din_ready_d  = (state_d == LOAD);
      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == DONE);
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         step_q       <= '0;
         bcnt_q       <= '0;
         sh_q         <= '0;
         din_ready_q  <= 1'b0;
         busy_q       <= 1'b0;
         step_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         step_q       <= step_d;
         bcnt_q       <= bcnt_d;
         sh_q         <= sh_d;
         din_ready_q  <= din_ready_d;
         busy_q       <= busy_d;
         step_done_q  <= step_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   aer_handshake_tx #(
      .ADDR_W (ADDR_W)
   ) u_hs (
      .CLK      (CLK),
      .rst_n    (rst_n),
      .start    (hs_start),
      .addr_in  (hs_addr),
      .aer_ack  (aer_ack),
      .aer_req  (aer_req),
      .aer_addr (aer_addr),
      .done     (hs_done)
   );

   assign din_ready  = din_ready_q;
   assign busy       = busy_q;
   assign step_done  = step_done_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_aer_spike_serializer.sv
// Directed bench for aer_spike_serializer: four configurations side by side,
// each with its own 4-phase ack responder and event recorder.
module tb_aer_spike_serializer;

   localparam int N_DUT = 4;
   localparam int NI_T  [N_DUT] = '{8, 8, 6, 8};
   localparam int NS_T  [N_DUT] = '{1, 1, 1, 3};
   localparam int MSB_T [N_DUT] = '{1, 0, 1, 1};

   logic        CLK   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_s     [N_DUT] = '{default: 1'b0};
   logic [3:0]  din_s       [N_DUT] = '{default: 4'h0};
   logic        din_valid_s [N_DUT] = '{default: 1'b0};
   logic        aer_ack_s   [N_DUT] = '{default: 1'b0};
   logic        din_ready_s [N_DUT];
   logic        aer_req_s   [N_DUT];
   logic [11:0] aer_addr_s  [N_DUT];
   logic        busy_s      [N_DUT];
   logic        step_done_s [N_DUT];
   logic        frame_done_s[N_DUT];

   logic [11:0] ev_addr  [N_DUT][64];
   int          ev_cnt   [N_DUT] = '{default: 0};
   int          viol     [N_DUT] = '{default: 0};
   int          sd_cnt   [N_DUT] = '{default: 0};
   int          fd_cnt   [N_DUT] = '{default: 0};
   int          fd_sd_at [N_DUT] = '{default: 0};
   int          ack_cnt  [N_DUT] = '{default: 0};
   int          lo_dly   [N_DUT] = '{default: 2};
   logic        prev_req [N_DUT] = '{default: 1'b0};
   logic [11:0] prev_addr[N_DUT] = '{default: 12'h000};

   int n_pass  = 0;
   int n_total = 0;

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      aer_spike_serializer #(
         .DATA_WIDTH (4),
         .NUM_INPUTS (NI_T[g]),
         .NUM_STEPS  (NS_T[g]),
         .ADDR_W     (12),
         .MSB_FIRST  (MSB_T[g])
      ) u_dut (
         .CLK        (CLK),
         .rst_n      (rst_n),
         .start      (start_s[g]),
         .din        (din_s[g]),
         .din_valid  (din_valid_s[g]),
         .din_ready  (din_ready_s[g]),
         .aer_req    (aer_req_s[g]),
         .aer_ack    (aer_ack_s[g]),
         .aer_addr   (aer_addr_s[g]),
         .busy       (busy_s[g]),
         .step_done  (step_done_s[g]),
         .frame_done (frame_done_s[g])
      );
   end

   // Event recorder plus ack responder: ack follows req after 2 cycles on the
   // rising side and lo_dly cycles on the falling side.
   initial begin
      forever begin
         @(negedge CLK);
         for (int k = 0; k < N_DUT; k++) begin
            if (aer_req_s[k] && !prev_req[k]) begin
               if (aer_ack_s[k]) viol[k]++;
               if (ev_cnt[k] < 64) ev_addr[k][ev_cnt[k]] = aer_addr_s[k];
               ev_cnt[k]++;
            end
            if (aer_req_s[k] && prev_req[k] && aer_addr_s[k] != prev_addr[k]) viol[k]++;
            if (step_done_s[k]) sd_cnt[k]++;
            if (frame_done_s[k]) begin
               fd_cnt[k]++;
               fd_sd_at[k] = sd_cnt[k];
            end
            prev_req[k]  = aer_req_s[k];
            prev_addr[k] = aer_addr_s[k];
            if (aer_req_s[k] != aer_ack_s[k]) begin
               ack_cnt[k]++;
               if (ack_cnt[k] >= (aer_req_s[k] ? 2 : lo_dly[k])) begin
                  aer_ack_s[k] = aer_req_s[k];
                  ack_cnt[k]   = 0;
               end
            end else begin
               ack_cnt[k] = 0;
            end
         end
      end
   end

   task automatic pulse_start(input int k);
      @(negedge CLK);
      start_s[k] = 1'b1;
      @(negedge CLK);
      start_s[k] = 1'b0;
   endtask

   task automatic drive_word(input int k, input logic [3:0] w);
      bit acc;
      acc = 1'b0;
      @(negedge CLK);
      din_s[k]       = w;
      din_valid_s[k] = 1'b1;
      for (int c = 0; c < 200 && !acc; c++) begin
         if (din_ready_s[k]) begin
            @(posedge CLK);
            #1;
            acc = 1'b1;
         end else begin
            @(negedge CLK);
         end
      end
      din_valid_s[k] = 1'b0;
      n_total++;
      if (!acc) $display("FAIL word_accept dut%0d: word %b accepted=%0d, required 1", k, w, acc);
      else n_pass++;
   endtask

   task automatic wait_frame(input int k, input int fd_base);
      int c;
      c = 0;
      while (fd_cnt[k] == fd_base && c < 1000) begin
         @(negedge CLK);
         #1;
         c++;
      end
      n_total++;
      if (fd_cnt[k] == fd_base) $display("FAIL frame_timeout dut%0d: frame_done count %0d, required %0d", k, fd_cnt[k], fd_base + 1);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge CLK);
      for (int k = 0; k < N_DUT; k++) begin
         n_total++;
         if (aer_req_s[k] !== 1'b0) $display("FAIL reset_req dut%0d: got %b, expected 0", k, aer_req_s[k]);
         else n_pass++;
         n_total++;
         if (aer_addr_s[k] !== 12'h000) $display("FAIL reset_addr dut%0d: got %h, expected 000", k, aer_addr_s[k]);
         else n_pass++;
         n_total++;
         if (din_ready_s[k] !== 1'b0) $display("FAIL reset_ready dut%0d: got %b, expected 0", k, din_ready_s[k]);
         else n_pass++;
         n_total++;
         if (busy_s[k] !== 1'b0) $display("FAIL reset_busy dut%0d: got %b, expected 0", k, busy_s[k]);
         else n_pass++;
         n_total++;
         if (step_done_s[k] !== 1'b0 || frame_done_s[k] !== 1'b0)
            $display("FAIL reset_done dut%0d: got step=%b frame=%b, expected 0 0", k, step_done_s[k], frame_done_s[k]);
         else n_pass++;
      end
      @(negedge CLK);
      rst_n = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_msb_first();
      int eb, sb, fb, vb;
      logic [11:0] exp_a [3];
      exp_a = '{12'h000, 12'h007, 12'h400};
      eb = ev_cnt[0]; sb = sd_cnt[0]; fb = fd_cnt[0]; vb = viol[0];
      pulse_start(0);
      #1;
      n_total++;
      if (busy_s[0] !== 1'b1 || din_ready_s[0] !== 1'b1)
         $display("FAIL msb_load_entry: got busy=%b ready=%b, expected 1 1", busy_s[0], din_ready_s[0]);
      else n_pass++;
      drive_word(0, 4'b1000);
      @(negedge CLK); #1;
      n_total++;
      if (aer_req_s[0] !== 1'b0) $display("FAIL msb_req_early: got %b, expected 0", aer_req_s[0]);
      else n_pass++;
      @(negedge CLK); #1;
      n_total++;
      if (aer_req_s[0] !== 1'b1 || aer_addr_s[0] !== 12'h000)
         $display("FAIL msb_req_latency: got req=%b addr=%h, expected 1 000", aer_req_s[0], aer_addr_s[0]);
      else n_pass++;
      drive_word(0, 4'b0001);
      wait_frame(0, fb);
      n_total++;
      if (ev_cnt[0] - eb !== 3) $display("FAIL msb_event_count: got %0d, expected 3", ev_cnt[0] - eb);
      else n_pass++;
      for (int j = 0; j < 3; j++) begin
         n_total++;
         if (ev_addr[0][eb + j] !== exp_a[j]) $display("FAIL msb_addr%0d: got %h, expected %h", j, ev_addr[0][eb + j], exp_a[j]);
         else n_pass++;
      end
      n_total++;
      if (sd_cnt[0] - sb !== 1 || fd_cnt[0] - fb !== 1)
         $display("FAIL msb_pulses: got step=%0d frame=%0d, expected 1 1", sd_cnt[0] - sb, fd_cnt[0] - fb);
      else n_pass++;
      n_total++;
      if (viol[0] !== vb) $display("FAIL msb_protocol: got %0d violations, expected 0", viol[0] - vb);
      else n_pass++;
      @(negedge CLK); #1;
      n_total++;
      if (busy_s[0] !== 1'b0) $display("FAIL msb_idle_after: got busy=%b, expected 0", busy_s[0]);
      else n_pass++;
   endtask

   task automatic test_lsb_first();
      int eb, fb;
      logic [11:0] exp_a [3];
      exp_a = '{12'h003, 12'h004, 12'h400};
      eb = ev_cnt[1]; fb = fd_cnt[1];
      pulse_start(1);
      drive_word(1, 4'b1000);
      drive_word(1, 4'b0001);
      wait_frame(1, fb);
      n_total++;
      if (ev_cnt[1] - eb !== 3) $display("FAIL lsb_event_count: got %0d, expected 3", ev_cnt[1] - eb);
      else n_pass++;
      for (int j = 0; j < 3; j++) begin
         n_total++;
         if (ev_addr[1][eb + j] !== exp_a[j]) $display("FAIL lsb_addr%0d: got %h, expected %h", j, ev_addr[1][eb + j], exp_a[j]);
         else n_pass++;
      end
   endtask

   task automatic test_partial_word();
      int eb, fb, sb;
      logic [11:0] exp_a;
      eb = ev_cnt[2]; fb = fd_cnt[2]; sb = sd_cnt[2];
      pulse_start(2);
      drive_word(2, 4'b1111);
      drive_word(2, 4'b1111);
      wait_frame(2, fb);
      n_total++;
      if (ev_cnt[2] - eb !== 7) $display("FAIL partial_event_count: got %0d, expected 7", ev_cnt[2] - eb);
      else n_pass++;
      for (int j = 0; j < 7; j++) begin
         exp_a = (j < 6) ? 12'(j) : 12'h400;
         n_total++;
         if (ev_addr[2][eb + j] !== exp_a) $display("FAIL partial_addr%0d: got %h, expected %h", j, ev_addr[2][eb + j], exp_a);
         else n_pass++;
      end
      n_total++;
      if (sd_cnt[2] - sb !== 1) $display("FAIL partial_step_done: got %0d, expected 1", sd_cnt[2] - sb);
      else n_pass++;
   endtask

   task automatic test_multi_step();
      int eb, fb, sb;
      logic [11:0] exp_a [3];
      exp_a = '{12'h400, 12'h401, 12'h402};
      eb = ev_cnt[3]; fb = fd_cnt[3]; sb = sd_cnt[3];
      pulse_start(3);
      for (int w = 0; w < 6; w++) drive_word(3, 4'b0000);
      wait_frame(3, fb);
      n_total++;
      if (ev_cnt[3] - eb !== 3) $display("FAIL steps_event_count: got %0d, expected 3", ev_cnt[3] - eb);
      else n_pass++;
      for (int j = 0; j < 3; j++) begin
         n_total++;
         if (ev_addr[3][eb + j] !== exp_a[j]) $display("FAIL steps_marker%0d: got %h, expected %h", j, ev_addr[3][eb + j], exp_a[j]);
         else n_pass++;
      end
      n_total++;
      if (sd_cnt[3] - sb !== 3) $display("FAIL steps_step_done: got %0d, expected 3", sd_cnt[3] - sb);
      else n_pass++;
      n_total++;
      if (fd_sd_at[3] !== sb + 3 || fd_cnt[3] - fb !== 1)
         $display("FAIL steps_frame_order: got step_done before frame=%0d frames=%0d, expected %0d 1", fd_sd_at[3], fd_cnt[3] - fb, sb + 3);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int eb, fb, c;
      pulse_start(0);
      drive_word(0, 4'b1000);
      c = 0;
      while (!(aer_req_s[0] && aer_ack_s[0]) && c < 100) begin
         @(negedge CLK); #1;
         c++;
      end
      n_total++;
      if (!(aer_req_s[0] && aer_ack_s[0])) $display("FAIL rstmid_handshake: got req=%b ack=%b, expected 1 1", aer_req_s[0], aer_ack_s[0]);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (aer_req_s[0] !== 1'b0 || aer_addr_s[0] !== 12'h000)
         $display("FAIL rstmid_async: got req=%b addr=%h, expected 0 000", aer_req_s[0], aer_addr_s[0]);
      else n_pass++;
      n_total++;
      if (busy_s[0] !== 1'b0 || din_ready_s[0] !== 1'b0)
         $display("FAIL rstmid_idle: got busy=%b ready=%b, expected 0 0", busy_s[0], din_ready_s[0]);
      else n_pass++;
      @(negedge CLK);
      rst_n = 1'b1;
      repeat (5) @(negedge CLK);
      #1;
      eb = ev_cnt[0]; fb = fd_cnt[0];
      pulse_start(0);
      drive_word(0, 4'b1000);
      drive_word(0, 4'b0000);
      wait_frame(0, fb);
      n_total++;
      if (ev_cnt[0] - eb !== 2) $display("FAIL rstmid_event_count: got %0d, expected 2", ev_cnt[0] - eb);
      else n_pass++;
      n_total++;
      if (ev_addr[0][eb] !== 12'h000) $display("FAIL rstmid_restart_addr: got %h, expected 000", ev_addr[0][eb]);
      else n_pass++;
      n_total++;
      if (ev_addr[0][eb + 1] !== 12'h400) $display("FAIL rstmid_marker: got %h, expected 400", ev_addr[0][eb + 1]);
      else n_pass++;
   endtask

   task automatic test_ack_hold_start();
      int eb, fb, vb, c, bad;
      logic [11:0] exp_a [3];
      exp_a = '{12'h000, 12'h001, 12'h400};
      lo_dly[0] = 10;
      eb = ev_cnt[0]; fb = fd_cnt[0]; vb = viol[0];
      pulse_start(0);
      drive_word(0, 4'b1100);
      c = 0;
      while (!(aer_req_s[0] && aer_ack_s[0]) && c < 100) begin
         @(negedge CLK); #1;
         c++;
      end
      while (aer_req_s[0] && c < 100) begin
         @(negedge CLK); #1;
         c++;
      end
      n_total++;
      if (c >= 100) $display("FAIL hold_handshake: got %0d cycles, expected req drop within 100", c);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK); #1;
         if (i == 2) start_s[0] = 1'b1;
         if (i == 3) start_s[0] = 1'b0;
         if (aer_ack_s[0] && aer_req_s[0]) bad++;
      end
      n_total++;
      if (bad !== 0) $display("FAIL hold_no_req_while_ack: got %0d cycles with req, expected 0", bad);
      else n_pass++;
      drive_word(0, 4'b0000);
      wait_frame(0, fb);
      n_total++;
      if (ev_cnt[0] - eb !== 3) $display("FAIL hold_event_count: got %0d, expected 3", ev_cnt[0] - eb);
      else n_pass++;
      for (int j = 0; j < 3; j++) begin
         n_total++;
         if (ev_addr[0][eb + j] !== exp_a[j]) $display("FAIL hold_addr%0d: got %h, expected %h", j, ev_addr[0][eb + j], exp_a[j]);
         else n_pass++;
      end
      n_total++;
      if (viol[0] !== vb || fd_cnt[0] - fb !== 1)
         $display("FAIL hold_protocol: got violations=%0d frames=%0d, expected 0 1", viol[0] - vb, fd_cnt[0] - fb);
      else n_pass++;
      @(negedge CLK); #1;
      n_total++;
      if (busy_s[0] !== 1'b0) $display("FAIL hold_idle_after: got busy=%b, expected 0", busy_s[0]);
      else n_pass++;
      lo_dly[0] = 2;
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_partial_word();
      test_multi_step();
      test_reset_mid();
      test_ack_hold_start();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
